regfile_scoreboard: RTL and testbench

//  32-entry register file with per-register pending (scoreboard) bits, consuming the
//  one-hot write-select produced by a Five_32Decoder instance on wr_addr. Sits between

---
 rtl/regfile_scoreboard_if.sv | 38 +++
 rtl/regfile_scoreboard.sv | 106 ++++++++++
 tb/tb_regfile_scoreboard.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
//   Bundles the writeback, issue and read-port signals of regfile_scoreboard.
//   master : issue/writeback/read-address driver (pipeline or testbench)
//   slave  : the register file itself
//   Signals:
//     wr_en/wr_addr/wr_data       writeback strobe, index, data
//     iss_en/iss_addr             issue strobe and destination index
//     rd_addr_a/rd_data_a/rd_pend_a  read port A
//     rd_addr_b/rd_data_b/rd_pend_b  read port B
//     pend_vec                    registered scoreboard, bit i = reg i pending
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
    parameter int WIDTH = 64
);
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             iss_en;
    logic [4:0]       iss_addr;
    logic [4:0]       rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic             rd_pend_a;
    logic [4:0]       rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_pend_b;
    logic [31:0]      pend_vec;

    modport master (
        output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_pend_a, rd_data_b, rd_pend_b, pend_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_pend_a, rd_data_b, rd_pend_b, pend_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   32-entry register file with a per-register pending (scoreboard) bit.
//   Register 31 is the hardwired zero register: never stored, never pending.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset (clears registers and scoreboard)
//     bus      regfile_scoreboard_if.slave (writeback, issue, two read ports,
//              registered pend_vec)
//   Parameters:
//     WIDTH    register data width
//     BYPASS   1: same-cycle writeback forwarding on read data and pend flags
// ---------------------------------------------------------------------------

// 5-to-32 one-hot decoder used for the writeback select.
module Five_32Decoder (
    input  logic [4:0]  sel,
    output logic [31:0] onehot
);
    assign onehot = 32'd1 << sel;
endmodule

module regfile_scoreboard #(
    parameter int WIDTH  = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_scoreboard_if.slave  bus
);
    localparam logic [4:0] XZR = 5'd31;

    logic [31:0]      wr_sel;
    logic [31:0]      clr_vec;
    logic [31:0]      set_vec;

    // Only registers 0..30 have storage; index 31 reads as zero.
    logic [WIDTH-1:0] regs_q [31];
    logic [WIDTH-1:0] regs_d [31];
    logic [30:0]      pend_q;
    logic [30:0]      pend_d;

    Five_32Decoder u_wr_dec (
        .sel    (bus.wr_addr),
        .onehot (wr_sel)
    );

    always_comb begin
        clr_vec = bus.wr_en  ? wr_sel                 : 32'd0;
        set_vec = bus.iss_en ? (32'd1 << bus.iss_addr) : 32'd0;
    end

    // NOTE: every always_comb output gets a full default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < 31; i++) begin
            if (clr_vec[i]) regs_d[i] = bus.wr_data;
        end
        // Set after clear: a same-cycle new producer keeps the register pending.
        pend_d = (pend_q & ~clr_vec[30:0]) | set_vec[30:0];
    end

    // NOTE: the storage array is reset explicitly because zeros after reset are
    // architecturally visible; state updates use non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 31; i++) regs_q[i] <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign bus.pend_vec = {1'b0, pend_q};

    function automatic logic [WIDTH-1:0] read_data(input logic [4:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (addr != XZR) begin
            if (BYPASS && clr_vec[addr]) val = bus.wr_data;
            else                         val = regs_q[addr];
        end
        return val;
    endfunction

    // With bypass, a writeback in flight clears the flag unless a new issue
    // to the same register lands in the same cycle.
    function automatic logic read_pend(input logic [4:0] addr);
        logic val;
        val = 1'b0;
        if (addr != XZR) begin
            if (BYPASS && clr_vec[addr]) val = set_vec[addr];
            else                         val = pend_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        bus.rd_data_a = read_data(bus.rd_addr_a);
        bus.rd_pend_a = read_pend(bus.rd_addr_a);
        bus.rd_data_b = read_data(bus.rd_addr_b);
        bus.rd_pend_b = read_pend(bus.rd_addr_b);
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Directed bench driving a BYPASS=1 and a BYPASS=0 instance with identical
//   stimulus; inputs change on the falling edge, outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    regfile_scoreboard_if #(.WIDTH(64)) bus_b ();   // bypass instance
    regfile_scoreboard_if #(.WIDTH(64)) bus_n ();   // no-bypass instance

    regfile_scoreboard #(.WIDTH(64), .BYPASS(1'b1)) dut_byp (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    regfile_scoreboard #(.WIDTH(64), .BYPASS(1'b0)) dut_nob (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_n.slave)
    );

    // Mirror stimulus onto the no-bypass instance.
    assign bus_n.wr_en     = bus_b.wr_en;
    assign bus_n.wr_addr   = bus_b.wr_addr;
    assign bus_n.wr_data   = bus_b.wr_data;
    assign bus_n.iss_en    = bus_b.iss_en;
    assign bus_n.iss_addr  = bus_b.iss_addr;
    assign bus_n.rd_addr_a = bus_b.rd_addr_a;
    assign bus_n.rd_addr_b = bus_b.rd_addr_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus_b.wr_en  = 1'b0;
        bus_b.iss_en = 1'b0;
    endtask

    task automatic drive_wr(input logic [4:0] addr, input logic [63:0] data);
        bus_b.wr_en   = 1'b1;
        bus_b.wr_addr = addr;
        bus_b.wr_data = data;
    endtask

    task automatic drive_iss(input logic [4:0] addr);
        bus_b.iss_en   = 1'b1;
        bus_b.iss_addr = addr;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.iss_en = 1'b0; bus_b.iss_addr = '0;
        bus_b.rd_addr_a = 5'd5; bus_b.rd_addr_b = 5'd7;

        // Reset state
        #2;
        check("rst_pend_vec", bus_b.pend_vec, 64'h0);
        check("rst_rd_a",     bus_b.rd_data_a, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();

        // Write forwarding on port A
        drive_wr(5'd5, 64'hDEAD_BEEF);
        #1;
        check("byp_fwd_a",   bus_b.rd_data_a, 64'hDEAD_BEEF);
        check("nob_old_a",   bus_n.rd_data_a, 64'h0);
        next_cycle();
        idle();
        #1;
        check("byp_after_a", bus_b.rd_data_a, 64'hDEAD_BEEF);
        check("nob_after_a", bus_n.rd_data_a, 64'hDEAD_BEEF);

        // Issue then writeback on register 7
        @(negedge clk);
        drive_iss(5'd7);
        #1;
        check("iss_pre_vec", bus_b.pend_vec, 64'h0);
        next_cycle();
        idle();
        #1;
        check("iss_vec",     bus_b.pend_vec, 64'h80);
        check("iss_pend_b",  bus_b.rd_pend_b, 64'h1);
        check("iss_pend_bn", bus_n.rd_pend_b, 64'h1);
        @(negedge clk);
        drive_wr(5'd7, 64'h77);
        #1;
        check("wb_byp_pend_b", bus_b.rd_pend_b, 64'h0);
        check("wb_nob_pend_b", bus_n.rd_pend_b, 64'h1);
        next_cycle();
        idle();
        #1;
        check("wb_vec",      bus_b.pend_vec, 64'h0);
        check("wb_data_b",   bus_b.rd_data_b, 64'h77);

        // Same-cycle issue and writeback: new producer wins
        @(negedge clk);
        drive_iss(5'd7);
        next_cycle();
        drive_iss(5'd7);
        drive_wr(5'd7, 64'h1234);
        #1;
        check("both_byp_pend_b", bus_b.rd_pend_b, 64'h1);
        check("both_byp_data_b", bus_b.rd_data_b, 64'h1234);
        next_cycle();
        idle();
        #1;
        check("both_vec",    bus_b.pend_vec, 64'h80);
        check("both_data_n", bus_n.rd_data_b, 64'h1234);

        // Register 31 ignores writes and issues
        @(negedge clk);
        bus_b.rd_addr_a = 5'd31;
        bus_b.rd_addr_b = 5'd31;
        drive_wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_iss(5'd31);
        #1;
        check("xzr_byp_a",    bus_b.rd_data_a, 64'h0);
        check("xzr_byp_pend", bus_b.rd_pend_b, 64'h0);
        next_cycle();
        idle();
        #1;
        check("xzr_vec",      bus_b.pend_vec, 64'h80);
        check("xzr_nob_b",    bus_n.rd_data_b, 64'h0);

        // Repeated issue to a pending register stays pending
        @(negedge clk);
        drive_iss(5'd3);
        next_cycle();
        drive_iss(5'd3);
        next_cycle();
        idle();
        #1;
        check("reiss_vec", bus_b.pend_vec, 64'h88);

        // Sweep: write index value into 0..30
        @(negedge clk);
        for (int i = 0; i < 31; i++) begin
            drive_wr(5'(i), 64'(i) | 64'hA5_0000_0000);
            next_cycle();
        end
        idle();
        #1;
        check("sweep_vec", bus_b.pend_vec, 64'h0);
        for (int i = 0; i < 31; i++) begin
            bus_b.rd_addr_a = 5'(i);
            bus_b.rd_addr_b = 5'(30 - i);
            #1;
            check($sformatf("sweep_a%0d", i),  bus_b.rd_data_a, 64'(i) | 64'hA5_0000_0000);
            check($sformatf("sweep_b%0d", i),  bus_n.rd_data_b, 64'(30 - i) | 64'hA5_0000_0000);
        end
        bus_b.rd_addr_a = 5'd9;
        bus_b.rd_addr_b = 5'd9;
        #1;
        check("same_addr_ab", bus_b.rd_data_b, 64'hA5_0000_0009);

        // Mid-run reset clears everything immediately
        @(negedge clk);
        drive_iss(5'd4);
        next_cycle();
        idle();
        #1;
        check("pre_rst_vec", bus_b.pend_vec, 64'h10);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_vec",    bus_b.pend_vec,  64'h0);
        check("mid_rst_data_a", bus_b.rd_data_a, 64'h0);
        check("mid_rst_data_n", bus_n.rd_data_b, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        #1;
        check("post_rst_data", bus_b.rd_data_a, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
